// File: rtl/pad_input_filter.sv
// -----------------------------------------------------------------------------
// pad_input_filter
//
// Conditions the levels returned by the pad frame before SoC logic uses them.
// Each channel goes through a SYNC_STAGES-deep synchronizer and then a digital
// glitch filter. The filter passes a new level only after the synchronized
// input has disagreed with the current output for filt_len_i+1 consecutive
// cycles. Channels are independent; the filter length is shared.
//
// Optional feature macro: PAD_FILT_EDGE_EVT_EN
//   defined   : registered rise/fall pulses plus sticky per-channel status
//               flags that are cleared by evt_clr_i
//   undefined : rise_o, fall_o and evt_status_o are tied low and
//               evt_clr_i is ignored
//
// Parameters
//   NUM_PADS     number of filtered channels
//   CNT_W        width of filt_len_i and of each qualify counter
//   SYNC_STAGES  synchronizer depth, legal range 2..4
//   RESET_VAL    reset value of the sync chain and of pad_filt_o
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   pad_in_i      raw asynchronous pad levels
//   filt_en_i     per-channel filter enable (0 = synchronize only)
//   filt_len_i    glitch threshold L; a new level must hold for L+1 cycles
//   pad_filt_o    synchronized, filtered level
//   rise_o        one-cycle pulse when pad_filt_o goes 0->1
//   fall_o        one-cycle pulse when pad_filt_o goes 1->0
//   evt_status_o  sticky edge-seen flags
//   evt_clr_i     per-channel clear of evt_status_o
// -----------------------------------------------------------------------------
module pad_input_filter #(
    parameter int                  NUM_PADS    = 32,
    parameter int                  CNT_W       = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [NUM_PADS-1:0] RESET_VAL   = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_PADS-1:0] pad_in_i,
    input  logic [NUM_PADS-1:0] filt_en_i,
    input  logic [CNT_W-1:0]    filt_len_i,
    output logic [NUM_PADS-1:0] pad_filt_o,
    output logic [NUM_PADS-1:0] rise_o,
    output logic [NUM_PADS-1:0] fall_o,
    output logic [NUM_PADS-1:0] evt_status_o,
    input  logic [NUM_PADS-1:0] evt_clr_i
);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] sync_s;
    logic [NUM_PADS-1:0] filt_q;
    logic [NUM_PADS-1:0] filt_d;
    logic [NUM_PADS-1:0] mismatch;
    state_t              state_q [NUM_PADS];
    logic [CNT_W-1:0]    cnt_q   [NUM_PADS];

    // Synchronizer chain. Stage 0 captures the raw pad level, and the last
    // stage is the only one the filter is allowed to look at.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= pad_in_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign mismatch = sync_s ^ filt_q;

    // Next filtered level. A channel commits the synchronized level when
    // filtering is off, or when a mismatch is accepted immediately (L==0 while
    // stable) or after the qualify count reaches the live threshold.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (!filt_en_i[i]) begin
                filt_d[i] = sync_s[i];
            end else if (mismatch[i]) begin
                if (state_q[i] == STABLE) begin
                    if (filt_len_i == '0) begin
                        filt_d[i] = sync_s[i];
                    end
                end else if (cnt_q[i] >= filt_len_i) begin
                    filt_d[i] = sync_s[i];
                end
            end
        end
    end

    // Per-channel qualify FSM and filtered output register. Any cycle without
    // a mismatch drops back to STABLE, so a bouncing input restarts
    // qualification from a count of 1. The counter cannot wrap because it
    // stops advancing once it reaches the threshold.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_q <= RESET_VAL;
            for (int i = 0; i < NUM_PADS; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < NUM_PADS; i++) begin
                if (!filt_en_i[i]) begin
                    state_q[i] <= STABLE;
                    cnt_q[i]   <= '0;
                end else begin
                    case (state_q[i])
                        STABLE: begin
                            if (mismatch[i] && (filt_len_i != '0)) begin
                                state_q[i] <= QUALIFY;
                                cnt_q[i]   <= CNT_W'(1);
                            end
                        end
                        QUALIFY: begin
                            if (!mismatch[i] || (cnt_q[i] >= filt_len_i)) begin
                                state_q[i] <= STABLE;
                                cnt_q[i]   <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_q[i] <= STABLE;
                            cnt_q[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign pad_filt_o = filt_q;

`ifdef PAD_FILT_EDGE_EVT_EN
    logic [NUM_PADS-1:0] rise_d;
    logic [NUM_PADS-1:0] fall_d;
    logic [NUM_PADS-1:0] rise_q;
    logic [NUM_PADS-1:0] fall_q;
    logic [NUM_PADS-1:0] status_q;

    // Edges are taken from the next-vs-current filtered level, so each pulse
    // lines up with the first cycle pad_filt_o shows the new level. Reset
    // leaves filt_q at RESET_VAL with both sides equal, so no edge appears.
    assign rise_d = filt_d & ~filt_q;
    assign fall_d = ~filt_d & filt_q;

    // Event pulses and sticky status. A new edge in the same cycle as a
    // clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
        end else begin
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= (status_q & ~evt_clr_i) | rise_d | fall_d;
        end
    end

    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign evt_status_o = status_q;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^evt_clr_i;
    assign rise_o         = '0;
    assign fall_o         = '0;
    assign evt_status_o   = '0;
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// -----------------------------------------------------------------------------
// tb_pad_input_filter
//
// Self-checking bench for pad_input_filter (32 pads, 8-bit counter, 2 sync
// stages, reset value 0x000000F0). Directed vector tables and hand-written
// sequences cover reset, glitch rejection, qualify latency, bypass, L=0,
// live threshold changes and reset during qualification. A randomized phase
// compares all outputs against a run-length reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pad_input_filter;

    localparam int          NP = 32;
    localparam int          CW = 8;
    localparam int          SS = 2;
    localparam logic [31:0] RV = 32'h0000_00F0;
`ifdef PAD_FILT_EDGE_EVT_EN
    localparam logic        EVT_EN = 1'b1;
`else
    localparam logic        EVT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] filt_en;
    logic [CW-1:0] filt_len;
    logic [NP-1:0] evt_clr;
    logic [NP-1:0] pad_filt;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;
    logic [NP-1:0] evt_status;

    int errors = 0;
    int checks = 0;

    // Reference model state: the model holds the state after the next edge
    logic [NP-1:0] m_sync [$];
    logic [NP-1:0] m_out;
    logic [NP-1:0] m_rise;
    logic [NP-1:0] m_fall;
    logic [NP-1:0] m_stat;
    int            m_run [NP];

    pad_input_filter #(
        .NUM_PADS    (NP),
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .RESET_VAL   (RV)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pad_in_i     (pad_in),
        .filt_en_i    (filt_en),
        .filt_len_i   (filt_len),
        .pad_filt_o   (pad_filt),
        .rise_o       (rise),
        .fall_o       (fall),
        .evt_status_o (evt_status),
        .evt_clr_i    (evt_clr)
    );

    always #5 clk = ~clk;

    // Model: the filter sees the pad level from SS edges ago; a level is
    // committed once it has disagreed with the output for L+1 consecutive
    // samples (run counts prior disagreeing samples, threshold read live).
    task automatic stepModel();
        logic [NP-1:0] s;
        logic [NP-1:0] nxt;
        if (!rst_n) begin
            m_sync = {};
            for (int k = 0; k < SS; k++) m_sync.push_back(RV);
            m_out  = RV;
            m_rise = '0;
            m_fall = '0;
            m_stat = '0;
            for (int i = 0; i < NP; i++) m_run[i] = 0;
            return;
        end
        s   = m_sync[SS-1];
        nxt = m_out;
        for (int i = 0; i < NP; i++) begin
            if (!filt_en[i]) begin
                nxt[i]   = s[i];
                m_run[i] = 0;
            end else if (s[i] == m_out[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] >= int'(filt_len)) begin
                nxt[i]   = s[i];
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
            end
        end
        m_rise = EVT_EN ? (nxt & ~m_out) : 32'h0;
        m_fall = EVT_EN ? (~nxt & m_out) : 32'h0;
        m_stat = EVT_EN ? ((m_stat & ~evt_clr) | m_rise | m_fall) : 32'h0;
        m_out  = nxt;
        void'(m_sync.pop_back());
        m_sync.push_front(pad_in);
    endtask

    // Drive one cycle of inputs away from the active edge, advance the model
    // by that edge, and return at the following negedge for sampling.
    task automatic applyStimulus(input logic rst, input logic [NP-1:0] pad,
                                 input logic [NP-1:0] en, input logic [CW-1:0] len,
                                 input logic [NP-1:0] clr);
        rst_n    = rst;
        pad_in   = pad;
        filt_en  = en;
        filt_len = len;
        evt_clr  = clr;
        stepModel();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [NP-1:0] act,
                               input logic [NP-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed table for channel 0: {rst, pad0, clr0, exp_filt0, exp_rise0, exp_stat0}
    typedef struct packed {
        logic rst;
        logic pad0;
        logic clr0;
        logic exp_filt0;
        logic exp_rise0;
        logic exp_stat0;
    } vec_t;

    vec_t tbl [24];

    initial begin
        logic [NP-1:0] pad_r;
        logic [NP-1:0] en_r;
        logic [CW-1:0] len_r;
        logic          hist [$];
        logic          exp3;
        logic          prev3;
        logic          p3;

        tbl = '{
            6'b000_000, 6'b000_000, 6'b000_000, 6'b100_000,
            6'b110_000, 6'b110_000, 6'b110_000, 6'b110_000,
            6'b100_000, 6'b100_000, 6'b100_000, 6'b100_000,
            6'b110_000, 6'b110_000, 6'b110_000, 6'b110_000,
            6'b110_000, 6'b110_000, 6'b110_111, 6'b110_101,
            6'b110_101, 6'b110_101, 6'b111_100, 6'b110_100
        };

        rst_n = 1'b0; pad_in = '0; filt_en = '1; filt_len = 8'd4; evt_clr = '0;

        // Reset held three cycles
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, '1, 8'd4, '0);
        checkOutput("reset_filt",   pad_filt,   RV);
        checkOutput("reset_rise",   rise,       '0);
        checkOutput("reset_fall",   fall,       '0);
        checkOutput("reset_status", evt_status, '0);

        // Glitch rejection (4-cycle pulse, L=4) then qualification (7-cycle latency)
        for (int r = 0; r < 24; r++) begin
            applyStimulus(tbl[r].rst, {31'b0, tbl[r].pad0}, '1, 8'd4, {31'b0, tbl[r].clr0});
            checkOutput($sformatf("tbl%0d_filt0", r), {31'b0, pad_filt[0]},   {31'b0, tbl[r].exp_filt0});
            checkOutput($sformatf("tbl%0d_rise0", r), {31'b0, rise[0]},       {31'b0, tbl[r].exp_rise0 & EVT_EN});
            checkOutput($sformatf("tbl%0d_stat0", r), {31'b0, evt_status[0]}, {31'b0, tbl[r].exp_stat0 & EVT_EN});
        end

        // Channel 3 toggling every 3 cycles: bypass first, then enabled with L=0.
        // Output must equal the pad level sampled two rows earlier in both modes.
        hist  = {1'b0, 1'b0};
        prev3 = 1'b0;
        for (int k = 0; k < 48; k++) begin
            p3 = ((k / 3) % 2 == 0);
            hist.push_back(p3);
            if (k < 24) applyStimulus(1'b1, {28'b0, p3, 3'b001}, ~32'h8, 8'd4, '0);
            else        applyStimulus(1'b1, {28'b0, p3, 3'b001}, '1,     8'd0, '0);
            exp3 = hist[k];
            checkOutput($sformatf("byp%0d_filt3", k), {31'b0, pad_filt[3]}, {31'b0, exp3});
            checkOutput($sformatf("byp%0d_rise3", k), {31'b0, rise[3]},     {31'b0, exp3 & ~prev3 & EVT_EN});
            prev3 = exp3;
        end

        // Live threshold change: L=10 while qualifying a fall, drop to 3 at count 6
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, '0, '1, 8'd10, '0);
            checkOutput($sformatf("live%0d_filt0", j), {31'b0, pad_filt[0]}, 32'h1);
            checkOutput($sformatf("live%0d_fall0", j), {31'b0, fall[0]},     32'h0);
        end
        applyStimulus(1'b1, '0, '1, 8'd3, 32'h1);
        checkOutput("live_commit_filt0", {31'b0, pad_filt[0]},   32'h0);
        checkOutput("live_commit_fall0", {31'b0, fall[0]},       {31'b0, EVT_EN});
        checkOutput("live_setclr_stat0", {31'b0, evt_status[0]}, {31'b0, EVT_EN});
        applyStimulus(1'b1, '0, '1, 8'd3, '0);
        checkOutput("live_after_fall0",  {31'b0, fall[0]},       32'h0);
        checkOutput("live_after_stat0",  {31'b0, evt_status[0]}, {31'b0, EVT_EN});

        // Reset mid-qualification (L=8, count 5) discards the pending level
        for (int j = 0; j < 7; j++) begin
            applyStimulus(1'b1, 32'h1, '1, 8'd8, '0);
            checkOutput($sformatf("rq%0d_filt0", j), {31'b0, pad_filt[0]}, 32'h0);
        end
        applyStimulus(1'b0, 32'h1, '1, 8'd8, '0);
        checkOutput("rq_reset_filt",   pad_filt,   RV);
        checkOutput("rq_reset_rise",   rise,       '0);
        checkOutput("rq_reset_fall",   fall,       '0);
        checkOutput("rq_reset_status", evt_status, '0);
        for (int j = 8; j < 18; j++) begin
            applyStimulus(1'b1, 32'h1, '1, 8'd8, '0);
            checkOutput($sformatf("rq%0d_filt0", j), {31'b0, pad_filt[0]}, 32'h0);
            checkOutput($sformatf("rq%0d_rise0", j), {31'b0, rise[0]},     32'h0);
        end
        applyStimulus(1'b1, 32'h1, '1, 8'd8, '0);
        checkOutput("rq_commit_filt0", {31'b0, pad_filt[0]}, 32'h1);
        checkOutput("rq_commit_rise0", {31'b0, rise[0]},     {31'b0, EVT_EN});

        // Randomized phase against the reference model
        pad_r = '0; en_r = '1; len_r = 8'd3;
        for (int c = 0; c < 2; c++) applyStimulus(1'b0, pad_r, en_r, len_r, '0);
        for (int c = 0; c < 600; c++) begin
            pad_r = pad_r ^ ($urandom & $urandom & $urandom);
            if (c % 64 == 0) en_r = $urandom | $urandom;
            if ($urandom_range(0, 15) == 0) len_r = 8'($urandom_range(0, 6));
            applyStimulus(!(c == 300 || c == 301), pad_r, en_r, len_r, $urandom & $urandom);
            checkOutput($sformatf("rnd%0d_filt", c),   pad_filt,   m_out);
            checkOutput($sformatf("rnd%0d_rise", c),   rise,       m_rise);
            checkOutput($sformatf("rnd%0d_fall", c),   fall,       m_fall);
            checkOutput($sformatf("rnd%0d_status", c), evt_status, m_stat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
